// File: rtl/scan_shift_sequencer.sv
// Scan chain sequencer: shifts stimulus in and response out, settles SE, and pulses capture.
// Build option SCAN_RESP_MISR_EN folds the response stream into a 16-bit MISR (misr_sig).
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | shifting stimulus in (and the previous response out)
// SE_FALL | SE low, chain clock off, settling
// CAPTURE | SE low, chain clocked for the capture pulses
// SE_RISE | SE high, chain clock off, settling
// UNLOAD  | shifting the final response out
// DONE    | one-cycle completion pulse
module scan_shift_sequencer #(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16,
  parameter int SETTLE    = 2,
  parameter int CAP_MAX   = 4
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [2:0]       num_capture,
  input  logic             stim_data,
  input  logic             stim_valid,
  output logic             stim_ready,
  output logic             resp_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             scan_en,
  output logic             scan_in,
  input  logic             scan_out,
  output logic             chain_clk_en,
  output logic             busy,
  output logic             done,
`ifdef SCAN_RESP_MISR_EN
  output logic [15:0]      misr_sig,
`endif
  output logic [CNT_W-1:0] pattern_idx
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SE_FALL, CAPTURE, SE_RISE, UNLOAD, DONE
  } state_t;

  localparam logic [CNT_W-1:0] SET_M1   = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W:0]   ONE_X    = 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] shift_cnt, tmr, num_pat_q, cap_m1;
  logic [2:0]       num_cap_q, cap_clamped;
  logic             resp_rdy, unloading, stim_ok, resp_ok, fire, shift_last, tmr_zero;
  logic             run_start, more_patterns;

  assign resp_data  = scan_out;
  assign run_start  = (state == IDLE) && start && !abort;
  assign shift_last = (shift_cnt == LAST_BIT);
  assign tmr_zero   = (tmr == '0);
  assign cap_m1     = CNT_W'(num_cap_q) - CNT_W'(1);
  assign more_patterns = ({1'b0, pattern_idx} + ONE_X) < {1'b0, num_pat_q};

  always_comb begin
    cap_clamped = num_capture;
    if (num_capture == 3'd0)
      cap_clamped = 3'd1;
    else if (int'(num_capture) > CAP_MAX)
      cap_clamped = 3'(CAP_MAX);
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    scan_en      = 1'b0;
    scan_in      = 1'b0;
    chain_clk_en = 1'b0;
    stim_ready   = 1'b0;
    resp_valid   = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    unloading    = (state == UNLOAD) || ((state == LOAD) && (pattern_idx != '0));
    stim_ok      = (state == UNLOAD) ? 1'b1 : stim_valid;
    resp_ok      = unloading ? resp_rdy : 1'b1;
    fire         = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = (num_patterns == '0) ? DONE : LOAD;
      end
      LOAD, UNLOAD: begin
        fire         = stim_ok && resp_ok;
        scan_en      = 1'b1;
        scan_in      = (state == LOAD) ? stim_data : 1'b0;
        chain_clk_en = fire;
        stim_ready   = fire && (state == LOAD);
        resp_valid   = stim_ok && unloading;
        if (fire && shift_last)
          state_nxt = (state == LOAD) ? SE_FALL : DONE;
      end
      SE_FALL: begin
        if (tmr_zero) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        chain_clk_en = 1'b1;
        if (tmr_zero) state_nxt = SE_RISE;
      end
      SE_RISE: begin
        scan_en = 1'b1;
        if (tmr_zero) state_nxt = more_patterns ? LOAD : UNLOAD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Timers and the shift counter restart on every state change.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      shift_cnt   <= '0;
      tmr         <= '0;
      num_pat_q   <= '0;
      num_cap_q   <= 3'd1;
      pattern_idx <= '0;
    end else begin
      if (run_start) begin
        num_pat_q   <= num_patterns;
        num_cap_q   <= cap_clamped;
        pattern_idx <= '0;
      end else if ((state == SE_RISE) && (state_nxt == LOAD)) begin
        pattern_idx <= pattern_idx + CNT_W'(1);
      end

      if (state_nxt != state)
        shift_cnt <= '0;
      else if (fire)
        shift_cnt <= shift_cnt + CNT_W'(1);

      if (state_nxt != state) begin
        case (state_nxt)
          SE_FALL, SE_RISE: tmr <= SET_M1;
          CAPTURE:          tmr <= cap_m1;
          default:          tmr <= '0;
        endcase
      end else if (!tmr_zero) begin
        tmr <= tmr - CNT_W'(1);
      end
    end
  end

`ifdef SCAN_RESP_MISR_EN
  assign resp_rdy = 1'b1;

  // Polynomial x^16 + x^12 + x^5 + 1.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN)
      misr_sig <= '0;
    else if (run_start)
      misr_sig <= '0;
    else if (resp_valid && resp_rdy)
      misr_sig <= {misr_sig[14:0], 1'b0} ^ ({16{misr_sig[15] ^ resp_data}} & 16'h1021);
  end
`else
  assign resp_rdy = resp_ready;
`endif

endmodule
